// File: rtl/adsd_risc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : adsd_risc_ctrl
// Brief   : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for the 16-bit
//           RISC datapath, with run/halt control and retired-instruction count.
// Revision: 1.0 - initial release
// ============================================================================
module adsd_risc_ctrl #(
    parameter int         CNT_W   = 16,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             ctrl_zero,
    input  logic             ctrl_neg,
    input  logic             ctrl_ovf,
    output logic             pc_ld,
    output logic             ctrl_branch,
    output logic             ctrl_jump,
    output logic             ctrl_i_mem_oe,
    output logic             ctrl_rf_rd_sel,
    output logic             ctrl_rf_write_en,
    output logic             ctrl_alu_in2_sel,
    output logic             ctrl_d_mem_rw_,
    output logic             ctrl_d_mem_cs,
    output logic             ctrl_wdata_sel,
    output logic [3:0]       ctrl_aluop,
    output logic             halted,
    output logic             ovf_seen,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] c_OP_ADDI = 4'h7;
    localparam logic [3:0] c_OP_LW   = 4'h8;
    localparam logic [3:0] c_OP_SW   = 4'h9;
    localparam logic [3:0] c_OP_BEQ  = 4'hA;
    localparam logic [3:0] c_OP_BNEG = 4'hB;
    localparam logic [3:0] c_OP_JMP  = 4'hC;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [3:0] w_dec_aluop;
    logic       w_dec_in2;
    logic       w_dec_rd;
    logic       w_oe;

    // Opcode-derived datapath selects; opcode is stable until pc_ld.
    always_comb begin
        w_dec_aluop = 4'h0;
        w_dec_in2   = 1'b0;
        w_dec_rd    = 1'b0;
        if (opcode <= 4'h4) begin
            w_dec_aluop = opcode;
            w_dec_rd    = 1'b1;
        end else if (opcode <= 4'h6) begin
            w_dec_aluop = opcode;
            w_dec_in2   = 1'b1;
        end else if (opcode <= c_OP_SW) begin
            w_dec_in2   = 1'b1;
        end else if (opcode == c_OP_BEQ || opcode == c_OP_BNEG) begin
            w_dec_aluop = 4'h1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = run ? S_DECODE : S_FETCH;
            S_DECODE: w_next = (opcode == HALT_OP) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (opcode <= c_OP_ADDI)
                    w_next = S_WB;
                else if (opcode == c_OP_LW || opcode == c_OP_SW)
                    w_next = S_MEM;
                else
                    w_next = S_FETCH;
            end
            S_MEM:    w_next = (opcode == c_OP_LW) ? S_WB : S_FETCH;
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_ld            = 1'b0;
        ctrl_branch      = 1'b0;
        ctrl_jump        = 1'b0;
        w_oe             = 1'b0;
        ctrl_rf_rd_sel   = 1'b0;
        ctrl_rf_write_en = 1'b0;
        ctrl_alu_in2_sel = 1'b0;
        ctrl_d_mem_rw_   = 1'b1;
        ctrl_d_mem_cs    = 1'b0;
        ctrl_wdata_sel   = 1'b0;
        ctrl_aluop       = 4'h0;
        case (r_state)
            S_FETCH, S_DECODE: w_oe = 1'b1;
            S_EXEC: begin
                ctrl_aluop       = w_dec_aluop;
                ctrl_alu_in2_sel = w_dec_in2;
                if (opcode == c_OP_BEQ) begin
                    pc_ld       = 1'b1;
                    ctrl_branch = ctrl_zero;
                end else if (opcode == c_OP_BNEG) begin
                    pc_ld       = 1'b1;
                    ctrl_branch = ctrl_neg;
                end else if (opcode == c_OP_JMP) begin
                    pc_ld     = 1'b1;
                    ctrl_jump = 1'b1;
                end else if (opcode > c_OP_JMP) begin
                    pc_ld = 1'b1;
                end
            end
            S_MEM: begin
                ctrl_d_mem_cs    = 1'b1;
                ctrl_alu_in2_sel = 1'b1;
                ctrl_d_mem_rw_   = (opcode == c_OP_LW);
                pc_ld            = (opcode == c_OP_SW);
            end
            S_WB: begin
                ctrl_rf_write_en = 1'b1;
                pc_ld            = 1'b1;
                ctrl_aluop       = w_dec_aluop;
                ctrl_alu_in2_sel = w_dec_in2;
                ctrl_rf_rd_sel   = w_dec_rd;
                ctrl_wdata_sel   = (opcode != c_OP_LW);
            end
            default: ;
        endcase
        // FETCH is the reset state, so the IMEM enable is masked while rst is high.
        ctrl_i_mem_oe = w_oe & ~rst;
    end

    assign halted = (r_state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt <= '0;
            ovf_seen  <= 1'b0;
        end else begin
            if (pc_ld)
                instr_cnt <= instr_cnt + c_CNT_ONE;
            if (r_state == S_EXEC && ctrl_ovf &&
                (opcode == 4'h0 || opcode == 4'h1 || opcode == c_OP_ADDI))
                ovf_seen <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adsd_risc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_adsd_risc_ctrl
// Brief   : Scoreboard bench for adsd_risc_ctrl: per-cycle expected outputs
//           queued by the stimulus, popped and compared by a monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adsd_risc_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst, run, ctrl_zero, ctrl_neg, ctrl_ovf;
    logic [3:0]       opcode;
    logic             pc_ld, ctrl_branch, ctrl_jump, ctrl_i_mem_oe, ctrl_rf_rd_sel;
    logic             ctrl_rf_write_en, ctrl_alu_in2_sel, ctrl_d_mem_rw_, ctrl_d_mem_cs;
    logic             ctrl_wdata_sel, halted, ovf_seen;
    logic [3:0]       ctrl_aluop;
    logic [CNT_W-1:0] instr_cnt;

    adsd_risc_ctrl #(.CNT_W(CNT_W), .HALT_OP(4'hF)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .ctrl_zero(ctrl_zero), .ctrl_neg(ctrl_neg), .ctrl_ovf(ctrl_ovf),
        .pc_ld(pc_ld), .ctrl_branch(ctrl_branch), .ctrl_jump(ctrl_jump),
        .ctrl_i_mem_oe(ctrl_i_mem_oe), .ctrl_rf_rd_sel(ctrl_rf_rd_sel),
        .ctrl_rf_write_en(ctrl_rf_write_en), .ctrl_alu_in2_sel(ctrl_alu_in2_sel),
        .ctrl_d_mem_rw_(ctrl_d_mem_rw_), .ctrl_d_mem_cs(ctrl_d_mem_cs),
        .ctrl_wdata_sel(ctrl_wdata_sel), .ctrl_aluop(ctrl_aluop),
        .halted(halted), .ovf_seen(ovf_seen), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             pc_ld, br, jmp, oe, rd, we, in2, rw, cs, ws;
        logic [3:0]       alu;
        logic             halted, ovf_seen;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] mcnt;
    logic             movf;

    function automatic exp_t idle_exp();
        exp_t e = '0;
        e.rw       = 1'b1;
        e.cnt      = mcnt;
        e.ovf_seen = movf;
        return e;
    endfunction

    function automatic exp_t dut_now();
        exp_t a;
        a.pc_ld = pc_ld;          a.br  = ctrl_branch;      a.jmp = ctrl_jump;
        a.oe    = ctrl_i_mem_oe;  a.rd  = ctrl_rf_rd_sel;   a.we  = ctrl_rf_write_en;
        a.in2   = ctrl_alu_in2_sel; a.rw = ctrl_d_mem_rw_;  a.cs  = ctrl_d_mem_cs;
        a.ws    = ctrl_wdata_sel; a.alu = ctrl_aluop;       a.halted = halted;
        a.ovf_seen = ovf_seen;    a.cnt = instr_cnt;
        return a;
    endfunction

    task automatic push(input exp_t e);
        sb.push_back(e);
        if (e.pc_ld) mcnt = mcnt + 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from the ISA rules.
    task automatic issue(input logic [3:0] op, input logic z, input logic n,
                         input logic v, output int len);
        exp_t       e;
        logic [3:0] alu_e;
        logic       in2_e, rd_e;
        opcode = op; ctrl_zero = z; ctrl_neg = n; ctrl_ovf = v;
        e = idle_exp(); e.oe = 1'b1;
        push(e); push(e);
        len = 2;
        if (op == 4'hF) return;
        alu_e = (op <= 4'h6) ? op : ((op == 4'hA || op == 4'hB) ? 4'h1 : 4'h0);
        in2_e = (op >= 4'h5 && op <= 4'h9);
        rd_e  = (op <= 4'h4);
        e = idle_exp(); e.alu = alu_e; e.in2 = in2_e;
        if (op == 4'hA) begin e.pc_ld = 1'b1; e.br = z; end
        if (op == 4'hB) begin e.pc_ld = 1'b1; e.br = n; end
        if (op == 4'hC) begin e.pc_ld = 1'b1; e.jmp = 1'b1; end
        if (op == 4'hD || op == 4'hE) e.pc_ld = 1'b1;
        push(e); len++;
        if ((op == 4'h0 || op == 4'h1 || op == 4'h7) && v) movf = 1'b1;
        if (op == 4'h8 || op == 4'h9) begin
            e = idle_exp(); e.cs = 1'b1; e.in2 = 1'b1;
            e.rw = (op == 4'h8); e.pc_ld = (op == 4'h9);
            push(e); len++;
        end
        if (op <= 4'h8) begin
            e = idle_exp(); e.we = 1'b1; e.pc_ld = 1'b1;
            e.alu = alu_e; e.in2 = in2_e; e.rd = rd_e; e.ws = (op != 4'h8);
            push(e); len++;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input logic n, input logic v);
        int len;
        issue(op, z, n, v, len);
        repeat (len) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            a = dut_now();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL cycle_outputs at %0t actual=%h required=%h", $time, a, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   len;
        rst = 1'b1; run = 1'b0; opcode = 4'h0;
        ctrl_zero = 1'b0; ctrl_neg = 1'b0; ctrl_ovf = 1'b0;
        mcnt = '0; movf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_oe", {31'd0, ctrl_i_mem_oe}, 0);
        chk("reset_pc_ld", {31'd0, pc_ld}, 0);
        chk("reset_rw", {31'd0, ctrl_d_mem_rw_}, 1);
        chk("reset_cnt", {24'd0, instr_cnt}, 0);
        chk("reset_halted", {31'd0, halted}, 0);
        rst = 1'b0; run = 1'b1;

        run_instr(4'h0, 1'b0, 1'b0, 1'b0);
        run_instr(4'h8, 1'b0, 1'b0, 1'b0);
        run_instr(4'h9, 1'b0, 1'b0, 1'b0);
        run_instr(4'hA, 1'b1, 1'b0, 1'b0);
        run_instr(4'hA, 1'b0, 1'b1, 1'b0);
        run_instr(4'hB, 1'b0, 1'b1, 1'b0);
        run_instr(4'hC, 1'b0, 1'b0, 1'b0);
        run_instr(4'h7, 1'b0, 1'b0, 1'b1);

        repeat (200)
            run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), 1'($urandom));

        // run dropped during EXEC of an ADD: WB completes, then FETCH parks
        issue(4'h0, 1'b0, 1'b0, 1'b0, len);
        repeat (2) @(posedge clk);
        #1 run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        repeat (5) begin
            e = idle_exp(); e.oe = 1'b1;
            push(e);
            @(posedge clk);
            #1;
        end
        run = 1'b1;
        run_instr(4'h1, 1'b0, 1'b0, 1'b0);

        // asynchronous reset in the EXEC cycle of an ADD
        opcode = 4'h0; ctrl_ovf = 1'b1;
        e = idle_exp(); e.oe = 1'b1;
        push(e); push(e);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", {31'd0, ctrl_rf_write_en}, 0);
        chk("arst_pc_ld", {31'd0, pc_ld}, 0);
        chk("arst_oe", {31'd0, ctrl_i_mem_oe}, 0);
        chk("arst_aluop_in2", {27'd0, ctrl_aluop, ctrl_alu_in2_sel}, 0);
        chk("arst_cnt", {24'd0, instr_cnt}, 0);
        chk("arst_ovf_seen", {31'd0, ovf_seen}, 0);
        repeat (2) begin
            @(negedge clk);
            chk("arst_we_hold", {31'd0, ctrl_rf_write_en}, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        mcnt = '0; movf = 1'b0; ctrl_ovf = 1'b0;
        run_instr(4'h0, 1'b0, 1'b0, 1'b0);

        // counter wrap from all-ones to zero
        while (mcnt != '1) run_instr(4'hD, 1'b0, 1'b0, 1'b0);
        chk("cnt_all_ones", {24'd0, instr_cnt}, 32'hFF);
        run_instr(4'hD, 1'b0, 1'b0, 1'b0);
        chk("cnt_wrap", {24'd0, instr_cnt}, 0);

        // HALT: parks forever, nothing counted
        issue(4'hF, 1'b0, 1'b0, 1'b0, len);
        e = idle_exp(); e.halted = 1'b1;
        repeat (20) push(e);
        repeat (22) @(posedge clk);
        #1;
        chk("halt_halted", {31'd0, halted}, 1);
        chk("halt_cnt", {24'd0, instr_cnt}, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
